// File: rtl/ysyx_23060077_isram_pkg.sv
// Shared ISRAM constants, FSM state encoding and the LFSR step function.
// The random-delay build is selected with YSYX_23060077_ISRAM_RAND_DELAY_EN.
package ysyx_23060077_isram_pkg;

  localparam logic [31:0] ISRAM_BASE_ADDR  = 32'h8000_0000;
  localparam int          ISRAM_DEPTH_LOG2 = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } isram_state_e;

  // Fibonacci form, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/ysyx_23060077_lfsr8.sv
// Free-running 8-bit LFSR used to draw per-request latencies.
// Only instantiated when YSYX_23060077_ISRAM_RAND_DELAY_EN is defined.
module ysyx_23060077_lfsr8
  import ysyx_23060077_isram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= lfsr8_next(state_q);
    end
  end

  assign q = state_q;

endmodule

// File: rtl/ysyx_23060077_isram.sv
// Instruction-side memory responder: one outstanding fetch, injected latency, backdoor preload.
// Define YSYX_23060077_ISRAM_RAND_DELAY_EN for LFSR-driven latency; otherwise FIXED_LAT is used.
module ysyx_23060077_isram
  import ysyx_23060077_isram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = ISRAM_DEPTH_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(ISRAM_BASE_ADDR),
  parameter int                    FIXED_LAT  = 1,
  parameter int                    MAX_LAT    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  output logic                  r_ready_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  r_err_o,
  input  logic                  w_en_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WA    = ADDR_WIDTH - 2;

  if (FIXED_LAT < 0 || FIXED_LAT > 15 || MAX_LAT < 0 || MAX_LAT > 15) begin : g_lat_check
    $error("ysyx_23060077_isram: FIXED_LAT and MAX_LAT must lie in 0..15");
  end

  isram_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  load;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] raddr;
  logic [WA-1:0]         rwoff, wwoff;
  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic                  rfault, wfault;
  logic [DATA_WIDTH-1:0] rword;
  logic [3:0]            lat;

  // Word offsets from BASE_ADDR (assumed word-aligned); anything beyond the array or misaligned faults.
  assign raddr  = (state_q == IDLE) ? r_addr_i : addr_q;
  assign rwoff  = raddr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign ridx   = rwoff[DEPTH_LOG2-1:0];
  assign rfault = (raddr[1:0] != 2'b00) || (rwoff[WA-1:DEPTH_LOG2] != '0);

  assign wwoff  = w_addr_i[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign widx   = wwoff[DEPTH_LOG2-1:0];
  assign wfault = (w_addr_i[1:0] != 2'b00) || (wwoff[WA-1:DEPTH_LOG2] != '0);

  assign rword = (w_en_i && !wfault && (widx == ridx)) ? w_data_i : mem[ridx];

`ifdef YSYX_23060077_ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  ysyx_23060077_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (8'hA5),
    .q     (lfsr)
  );

  assign lat = (lfsr[3:0] > 4'(MAX_LAT)) ? 4'(MAX_LAT) : lfsr[3:0];
`else
  assign lat = 4'(FIXED_LAT);
`endif

  always_ff @(posedge clk) begin
    if (w_en_i && !wfault) begin
      mem[widx] <= w_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // The read word is captured on whichever edge enters RESP, so the FSM flags that edge with load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (r_valid_i) begin
          addr_d = r_addr_i;
          cnt_d  = lat;
          if (lat == 4'd0) begin
            state_d = RESP;
            load    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          load    = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      err_d  = rfault;
      data_d = rfault ? '0 : rword;
    end
  end

  assign r_ready_o = (state_q == RESP);
  assign r_data_o  = data_q;
  assign r_err_o   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_ysyx_23060077_isram.sv
// Directed bench: three ISRAM instances (fixed latency 1, 0, 5) sharing clock, reset and backdoor.
// Latency checks become range checks when YSYX_23060077_ISRAM_RAND_DELAY_EN is defined.
module tb_ysyx_23060077_isram;

  localparam int NDUT = 3;
  localparam int MAXL = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NDUT-1:0]       rValid;
  logic [NDUT-1:0][31:0] rAddr;
  logic [NDUT-1:0]       rReady;
  logic [NDUT-1:0][31:0] rData;
  logic [NDUT-1:0]       rErr;
  logic                  wEn;
  logic [31:0]           wAddr;
  logic [31:0]           wData;

  resp_t expQ[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  ysyx_23060077_isram #(.FIXED_LAT(1), .MAX_LAT(MAXL)) dutL1 (
    .clk(clk), .rst_n(rst_n), .r_valid_i(rValid[0]), .r_addr_i(rAddr[0]),
    .r_ready_o(rReady[0]), .r_data_o(rData[0]), .r_err_o(rErr[0]),
    .w_en_i(wEn), .w_addr_i(wAddr), .w_data_i(wData));

  ysyx_23060077_isram #(.FIXED_LAT(0), .MAX_LAT(MAXL)) dutL0 (
    .clk(clk), .rst_n(rst_n), .r_valid_i(rValid[1]), .r_addr_i(rAddr[1]),
    .r_ready_o(rReady[1]), .r_data_o(rData[1]), .r_err_o(rErr[1]),
    .w_en_i(wEn), .w_addr_i(wAddr), .w_data_i(wData));

  ysyx_23060077_isram #(.FIXED_LAT(5), .MAX_LAT(MAXL)) dutL5 (
    .clk(clk), .rst_n(rst_n), .r_valid_i(rValid[2]), .r_addr_i(rAddr[2]),
    .r_ready_o(rReady[2]), .r_data_o(rData[2]), .r_err_o(rErr[2]),
    .w_en_i(wEn), .w_addr_i(wAddr), .w_data_i(wData));

  function automatic int fixedLat(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkLatency(input int d, input int lat);
`ifdef YSYX_23060077_ISRAM_RAND_DELAY_EN
    checkOutput("latency_range", 32'(lat <= MAXL), 32'd1);
`else
    checkOutput("latency", lat, fixedLat(d));
`endif
  endtask

  task automatic backdoorWrite(input logic [31:0] addr, input logic [31:0] data);
    wEn = 1'b1; wAddr = addr; wData = data;
    @(negedge clk);
    wEn = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic applyStimulus(input int d, input logic [31:0] addr,
                               input logic [31:0] expData, input logic expErr);
    resp_t want;
    int    lat;
    bit    seen;
    rValid[d] = 1'b1;
    rAddr[d]  = addr;
    expQ.push_back('{data: expData, err: expErr});
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (rReady[d]) seen = 1'b1;
      else lat++;
    end
    rValid[d] = 1'b0;
    want = expQ.pop_front();
    checkOutput("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("data", rData[d], want.data);
      checkOutput("err", 32'(rErr[d]), 32'(want.err));
      checkLatency(d, lat);
      @(negedge clk);
      checkOutput("single_pulse", 32'(rReady[d]), 32'd0);
      checkOutput("err_idle", 32'(rErr[d]), 32'd0);
      checkOutput("data_hold", rData[d], want.data);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    resp_t want;
    rValid = '0; rAddr = '0; wEn = 1'b0; wAddr = '0; wData = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(rReady), 32'd0);
    checkOutput("rst_data", rData[0], 32'd0);
    checkOutput("rst_err", 32'(rErr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    backdoorWrite(32'h8000_0000, 32'h0000_0413);
    backdoorWrite(32'h8000_0004, 32'h0010_0073);
    backdoorWrite(32'h8000_000C, 32'h3333_3333);
    backdoorWrite(32'h8000_3FFC, 32'h0FFC_0FFC);
    backdoorWrite(32'h8000_4000, 32'h0BAD_0BAD);
    backdoorWrite(32'h8000_0001, 32'h0BAD_0001);
    for (int i = 16; i < 32; i++) backdoorWrite(32'h8000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));

    applyStimulus(0, 32'h8000_0000, 32'h0000_0413, 1'b0);
    applyStimulus(1, 32'h8000_0004, 32'h0010_0073, 1'b0);
    applyStimulus(2, 32'h8000_0000, 32'h0000_0413, 1'b0);
    applyStimulus(0, 32'h8000_3FFC, 32'h0FFC_0FFC, 1'b0);
    applyStimulus(0, 32'h8000_4000, 32'h0000_0000, 1'b1);
    applyStimulus(0, 32'h8000_0002, 32'h0000_0000, 1'b1);
    applyStimulus(1, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1);
    applyStimulus(0, 32'h8000_0004, 32'h0010_0073, 1'b0);

`ifndef YSYX_23060077_ISRAM_RAND_DELAY_EN
    // Valid held through RESP on the zero-latency instance: pulses two cycles apart.
    rValid[1] = 1'b1; rAddr[1] = 32'h8000_0004;
    @(negedge clk);
    checkOutput("hold_ready1", 32'(rReady[1]), 32'd1);
    @(negedge clk);
    checkOutput("hold_gap", 32'(rReady[1]), 32'd0);
    @(negedge clk);
    checkOutput("hold_ready2", 32'(rReady[1]), 32'd1);
    checkOutput("hold_data2", rData[1], 32'h0010_0073);
    rValid[1] = 1'b0;
    @(negedge clk);

    // Backdoor write to the same word on the edge entering RESP is forwarded.
    rValid[1] = 1'b1; rAddr[1] = 32'h8000_000C;
    wEn = 1'b1; wAddr = 32'h8000_000C; wData = 32'hDEAD_BEEF;
    expQ.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
    @(negedge clk);
    wEn = 1'b0; rValid[1] = 1'b0;
    want = expQ.pop_front();
    checkOutput("coll_ready", 32'(rReady[1]), 32'd1);
    checkOutput("coll_data", rData[1], want.data);
    @(negedge clk);
    applyStimulus(0, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0);

    // Reset two cycles after acceptance on the latency-5 instance aborts the request.
    rValid[2] = 1'b1; rAddr[2] = 32'h8000_0004;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; rValid[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_data", rData[2], 32'd0);
    checkOutput("abort_err", 32'(rErr[2]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (rReady[2]) pulses++;
      @(negedge clk);
    end
    checkOutput("abort_no_pulse", pulses, 32'd0);
    applyStimulus(2, 32'h8000_0004, 32'h0010_0073, 1'b0);
`endif

    // Dropped out-of-range write must not alias onto word 0.
    applyStimulus(1, 32'h8000_0000, 32'h0000_0413, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      int i;
      i = $urandom_range(16, 31);
      applyStimulus(0, 32'h8000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
